counter_seq: RTL and testbench
==============================

# counter_seq

Command-driven sequencer for the `counter_10` loadable decimal counter. Accepts opcodes over a valid/ready interface and drives the counter's `contral`, `load_enable` and `load_counter` inputs. Generates a prescaled count-enable tick and watches the counter's `oQ` feedback to detect a programmed target value. Sits between the top-level control logic (buttons/host) and the counter/display datapath.

## Interface

Parameters:
- `PRESCALE`, default 4: CLK cycles per `cnt_en` tick; legal range ≥1.
- `PW`, default `$clog2(PRESCALE)` (min 1): prescaler counter width.

Ports:
- `CLK` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: opcode.
  - 00 LOAD
  - 01 START
  - 10 STOP
  - 11 SETMODE
- `cmd_arg` in 4: load value, target, or mode (`cmd_arg[1:0]`).
- `oQ` in 4: counter value feedback.
- `contral` out 2: counter mode register.
- `load_enable` out 1: counter load strobe.
- `load_counter` out 4: value to load.
- `cnt_en` out 1: count tick, one-cycle pulse.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the target is reached.
- `err` out 1: one-cycle pulse when an illegal argument is rejected.

## Operation

- FSM states: IDLE, LOAD, RUN, DONE.
- `cmd_ready`:
  - 1 in IDLE.
  - In RUN, 1 only when `cmd_op`==STOP.
  - 0 in LOAD and DONE.
- IDLE, accepted command:
  - LOAD with arg ≤9: latch `load_counter`=arg, go to LOAD.
  - LOAD with arg >9: `err` pulse, stay in IDLE, `load_counter` unchanged.
  - START with arg ≤9: latch target, clear prescaler, go to RUN.
  - START with arg >9: `err` pulse, stay in IDLE.
  - SETMODE: `contral`←`cmd_arg[1:0]`, stay in IDLE.
  - STOP: no-op, accepted.
- LOAD: `load_enable`=1 for this single cycle, then IDLE.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - `cnt_en`=1 in the cycle the count equals PRESCALE-1.
  - `tick_seen` is set by the first `cnt_en` of this run.
  - If `tick_seen` && `oQ`==target, go to DONE.
  - Accepted STOP: go to IDLE, no `done`.
- DONE: `done`=1 for this one cycle, then IDLE.
- Simultaneous events:
  - STOP accepted in the same cycle as a target match: STOP wins, no `done`.
  - START with target equal to the current `oQ`: does not finish until at least one tick has been issued.
- `contral` holds through all states; it changes only on SETMODE or reset.

## Timing

- Reset values:
  - state IDLE
  - `contral`=00
  - `load_enable`=0
  - `load_counter`=0
  - `cnt_en`=0
  - `busy`=0
  - `done`=0
  - `err`=0
  - target=0, prescaler=0, `tick_seen`=0
  - `cmd_ready`=1 in the first cycle after reset deasserts.
- All outputs are registered except `cmd_ready`, which is combinational from state and `cmd_op`.
- LOAD accepted at edge N:
  - `load_enable`=1 during cycle N+1.
  - `cmd_ready` high again at N+2.
- SETMODE accepted at edge N: `contral` updated from N+1.
- START accepted at edge N:
  - RUN from N+1.
  - First `cnt_en` in cycle N+PRESCALE, then every PRESCALE cycles.
  - PRESCALE=1 gives `cnt_en` every RUN cycle.
- Target match sampled in cycle M: `done` in cycle M+1, IDLE from M+2.
- `err` asserts in the cycle after the rejecting edge.
- Reset asserted mid-RUN or mid-LOAD: all outputs return to reset values at the next edge, and any in-flight `load_enable` is cut.

## Structure

- Package `counter_seq_pkg`:
  - opcode localparams OP_LOAD/OP_START/OP_STOP/OP_SETMODE
  - state encoding
  - MAX_DIGIT=9
- Sub-module `tick_gen`:
  - Parameter PRESCALE.
  - Inputs: CLK, rst, clear, enable.
  - Output: `tick`.
  - Reused by other blocks that need a divided strobe.
- FSM, argument checking and target compare live in `counter_seq`.

## Test plan

- Reset, then LOAD arg=3 → `load_enable`=1 for exactly one cycle with `load_counter`=3; `busy`=1 for one cycle; `cmd_ready` low for one cycle.
- LOAD arg=12 → `err` pulse next cycle; `load_counter` stays 3; no `load_enable`.
- SETMODE arg=2 → `contral`=10 next cycle; it persists through a subsequent LOAD and START/STOP.
- PRESCALE=4, START target=7 with a behavioural counter model incrementing on `cnt_en` from 3 → `cnt_en` at cycles +4, +8, +12, +16; `done` pulses once, one cycle after `oQ`=7; then IDLE.
- START target=5 while `oQ`=5 → no `done` until after the first tick; STOP issued in the same cycle as the match → no `done`, IDLE next cycle.
- Assert `rst` mid-RUN → next cycle: all outputs at reset values, `cnt_en` silent, `cmd_ready`=1.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: opcodes, FSM encoding and digit limit shared by the
// counter_10 sequencer and its bench-side users.
package counter_seq_pkg;

   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_START   = 2'b01;
   localparam logic [1:0] OP_STOP    = 2'b10;
   localparam logic [1:0] OP_SETMODE = 2'b11;

   localparam logic [3:0] MAX_DIGIT  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // A load value or target must be a single decimal digit.
   function automatic logic digit_ok(input logic [3:0] value);
      return value <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: registered one-cycle strobe every PRESCALE enabled cycles.
// clear/enable describe the cycle that begins at the coming clock edge.
module tick_gen #(
   parameter int PRESCALE = 4,
   parameter int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic CLK,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] count_q, count_d;
   logic          tick_q, tick_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
      tick_d = enable && (count_d == LAST);
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/counter_seq.sv
// counter_seq: command-driven sequencer for the counter_10 decimal counter;
// loads, sets mode, runs with a prescaled tick and reports when a target is hit.
module counter_seq
   import counter_seq_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_arg,
   input  logic [3:0] oQ,
   output logic [1:0] contral,
   output logic       load_enable,
   output logic [3:0] load_counter,
   output logic       cnt_en,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_t     state_q, state_d;
   logic [1:0] contral_q, contral_d;
   logic [3:0] load_counter_q, load_counter_d;
   logic [3:0] target_q, target_d;
   logic       tick_seen_q, tick_seen_d;
   logic       load_enable_q, load_enable_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       pre_clear;
   logic       cmd_fire;

   // While running, only STOP may be taken so a run cannot be re-armed mid-flight.
   always_comb begin
      cmd_ready = 1'b0;
      case (state_q)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RUN:  cmd_ready = (cmd_op == OP_STOP);
         default: cmd_ready = 1'b0;
      endcase
   end

   assign cmd_fire = cmd_valid && cmd_ready;

   always_comb begin
      state_d        = state_q;
      contral_d      = contral_q;
      load_counter_d = load_counter_q;
      target_d       = target_q;
      tick_seen_d    = tick_seen_q;
      err_d          = 1'b0;
      pre_clear      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd_op)
                  OP_LOAD: begin
                     if (digit_ok(cmd_arg)) begin
                        load_counter_d = cmd_arg;
                        state_d        = ST_LOAD;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_START: begin
                     if (digit_ok(cmd_arg)) begin
                        target_d    = cmd_arg;
                        tick_seen_d = 1'b0;
                        pre_clear   = 1'b1;
                        state_d     = ST_RUN;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_SETMODE: contral_d = cmd_arg[1:0];
                  default: ;
               endcase
            end
         end
         ST_LOAD: state_d = ST_IDLE;
         ST_RUN: begin
            if (cnt_en) tick_seen_d = 1'b1;
            // An accepted STOP outranks a simultaneous target match.
            if (cmd_fire) begin
               state_d = ST_IDLE;
            end else if (tick_seen_q && (oQ == target_q)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      load_enable_d = (state_d == ST_LOAD);
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         contral_q      <= 2'b00;
         load_counter_q <= 4'd0;
         target_q       <= 4'd0;
         tick_seen_q    <= 1'b0;
         load_enable_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         contral_q      <= contral_d;
         load_counter_q <= load_counter_d;
         target_q       <= target_d;
         tick_seen_q    <= tick_seen_d;
         load_enable_q  <= load_enable_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   tick_gen #(
      .PRESCALE (PRESCALE),
      .PW       (PW)
   ) u_tick_gen (
      .CLK    (CLK),
      .rst    (rst),
      .clear  (pre_clear),
      .enable (state_d == ST_RUN),
      .tick   (cnt_en)
   );

   assign contral      = contral_q;
   assign load_enable  = load_enable_q;
   assign load_counter = load_counter_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_counter_seq.sv
// tb_counter_seq: table vectors, hand-written corner sequences and random
// stimulus checked against a behavioural model of the sequencer and counter.
module tb_counter_seq;

   localparam int P = 4;

   localparam logic [1:0] B_LOAD    = 2'b00;
   localparam logic [1:0] B_START   = 2'b01;
   localparam logic [1:0] B_STOP    = 2'b10;
   localparam logic [1:0] B_SETMODE = 2'b11;

   logic       CLK;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_arg;
   logic [3:0] oQ;
   logic [1:0] contral;
   logic       load_enable;
   logic [3:0] load_counter;
   logic       cnt_en;
   logic       busy;
   logic       done;
   logic       err;

   counter_seq #(.PRESCALE(P)) dut (
      .CLK          (CLK),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_arg      (cmd_arg),
      .oQ           (oQ),
      .contral      (contral),
      .load_enable  (load_enable),
      .load_counter (load_counter),
      .cnt_en       (cnt_en),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // {contral, load_enable, load_counter, cnt_en, busy, done, err, cmd_ready}
   logic [11:0] dut_vec;
   assign dut_vec = {contral, load_enable, load_counter, cnt_en, busy, done, err, cmd_ready};

   int n_tests = 0;
   int n_fail  = 0;

   // Environment counter_10 model feeding oQ.
   logic [3:0] q_env;
   logic       hold;
   assign oQ = q_env;

   // Behavioural sequencer model.
   logic [1:0] m_mode;
   logic [3:0] m_lc;
   logic [3:0] m_target;
   logic       m_le, m_done, m_err;
   logic       m_running, m_ticked;
   int         m_age;   // 1 in the first running cycle of a run

   logic [11:0] s_vec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_vec();
      logic busy_e, cnt_e, ready_e;
      busy_e  = m_le || m_running || m_done;
      cnt_e   = m_running && (m_age % P == 0);
      ready_e = m_running ? (cmd_op == B_STOP) : !busy_e;
      return {m_mode, m_le, m_lc, cnt_e, busy_e, m_done, m_err, ready_e};
   endfunction

   task automatic model_edge(input logic v, input logic [1:0] op, input logic [3:0] arg,
                             input logic r, input logic [3:0] q);
      logic idle, ready, fire, tick_now, in_run;
      in_run   = m_running;
      idle     = !(m_le || m_running || m_done);
      ready    = in_run ? (op == B_STOP) : idle;
      fire     = v && ready;
      tick_now = in_run && (m_age % P == 0);
      m_le = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (r) begin
         m_mode = 2'd0; m_lc = 4'd0; m_target = 4'd0;
         m_running = 1'b0; m_ticked = 1'b0; m_age = 0;
      end else if (idle) begin
         if (fire) begin
            case (op)
               B_LOAD: if (arg <= 4'd9) begin m_lc = arg; m_le = 1'b1; end else m_err = 1'b1;
               B_START: if (arg <= 4'd9) begin
                  m_target = arg; m_running = 1'b1; m_age = 1; m_ticked = 1'b0;
               end else m_err = 1'b1;
               B_SETMODE: m_mode = arg[1:0];
               default: ;
            endcase
         end
      end else if (in_run) begin
         if (fire) begin
            m_running = 1'b0;
         end else if (m_ticked && q == m_target) begin
            m_running = 1'b0;
            m_done    = 1'b1;
         end else begin
            if (tick_now) m_ticked = 1'b1;
            m_age++;
         end
      end
   endtask

   // Drive one cycle of inputs, compare all outputs with the model, then cross the edge.
   task automatic cycle(input logic v, input logic [1:0] op, input logic [3:0] arg, input logic r);
      logic [11:0] exp_v;
      logic        pre_le, pre_cnt;
      logic [3:0]  pre_lc;
      cmd_valid = v; cmd_op = op; cmd_arg = arg; rst = r;
      #1;
      exp_v = model_vec();
      s_vec = dut_vec;
      check("cycle", {20'd0, s_vec}, {20'd0, exp_v});
      pre_le = exp_v[9]; pre_lc = exp_v[8:5]; pre_cnt = exp_v[4];
      @(posedge CLK);
      #1;
      model_edge(v, op, arg, r, q_env);
      if (pre_le) q_env = pre_lc;
      else if (pre_cnt && !hold) q_env = (q_env == 4'd9) ? 4'd0 : 4'(q_env + 4'd1);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] arg;
      logic       le;
      logic [3:0] lc;
      logic       err;
      logic [1:0] mode;
      logic       busy;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] tick_mask, done_mask, busy_mask;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = B_LOAD; cmd_arg = 4'd0;
      q_env = 4'd0; hold = 1'b0;
      m_mode = 2'd0; m_lc = 4'd0; m_target = 4'd0; m_le = 1'b0; m_done = 1'b0;
      m_err = 1'b0; m_running = 1'b0; m_ticked = 1'b0; m_age = 0;

      vecs[0] = '{B_LOAD,    4'd3,  1'b1, 4'd3, 1'b0, 2'd0, 1'b1};
      vecs[1] = '{B_LOAD,    4'd12, 1'b0, 4'd3, 1'b1, 2'd0, 1'b0};
      vecs[2] = '{B_SETMODE, 4'd2,  1'b0, 4'd3, 1'b0, 2'd2, 1'b0};
      vecs[3] = '{B_LOAD,    4'd9,  1'b1, 4'd9, 1'b0, 2'd2, 1'b1};
      vecs[4] = '{B_LOAD,    4'd10, 1'b0, 4'd9, 1'b1, 2'd2, 1'b0};
      vecs[5] = '{B_START,   4'd15, 1'b0, 4'd9, 1'b1, 2'd2, 1'b0};
      vecs[6] = '{B_STOP,    4'd0,  1'b0, 4'd9, 1'b0, 2'd2, 1'b0};
      vecs[7] = '{B_SETMODE, 4'd7,  1'b0, 4'd9, 1'b0, 2'd3, 1'b0};
      vecs[8] = '{B_LOAD,    4'd0,  1'b1, 4'd0, 1'b0, 2'd3, 1'b1};
      vecs[9] = '{B_SETMODE, 4'd2,  1'b0, 4'd0, 1'b0, 2'd2, 1'b0};

      repeat (2) @(posedge CLK);
      #1;
      rst = 1'b0;
      #1;
      check("reset_state", {20'd0, dut_vec}, 32'h001);

      // Single-command vectors from IDLE.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, vecs[i].op, vecs[i].arg, 1'b0);
         check($sformatf("vec%0d", i), {23'd0, contral, load_enable, load_counter, err, busy},
               {23'd0, vecs[i].mode, vecs[i].le, vecs[i].lc, vecs[i].err, vecs[i].busy});
         cycle(1'b0, B_LOAD, 4'd0, 1'b0);
         cycle(1'b0, B_LOAD, 4'd0, 1'b0);
         check($sformatf("vec%0d_settle", i), {31'd0, load_enable}, 32'd0);
      end

      // Counter at 3 counting up to target 7.
      cycle(1'b1, B_LOAD, 4'd3, 1'b0);
      cycle(1'b0, B_LOAD, 4'd0, 1'b0);
      cycle(1'b1, B_START, 4'd7, 1'b0);
      tick_mask = '0; done_mask = '0; busy_mask = '0;
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b0, B_LOAD, 4'd0, 1'b0);
         tick_mask[k] = s_vec[4];
         done_mask[k] = s_vec[2];
         busy_mask[k] = s_vec[3];
      end
      check("tick_times", tick_mask, (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12) | (32'd1 << 16));
      check("done_time", done_mask, 32'd1 << 18);
      check("idle_after_done", {31'd0, busy_mask[19]}, 32'd0);

      // Target equal to the current oQ: no done before the first tick.
      cycle(1'b1, B_LOAD, 4'd5, 1'b0);
      cycle(1'b0, B_LOAD, 4'd0, 1'b0);
      hold = 1'b1;
      cycle(1'b1, B_START, 4'd5, 1'b0);
      done_mask = '0;
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, B_LOAD, 4'd0, 1'b0);
         done_mask[k] = s_vec[2];
      end
      check("equal_target_done", done_mask, 32'd1 << 6);

      // STOP in the same cycle as the match.
      cycle(1'b1, B_START, 4'd5, 1'b0);
      done_mask = '0; busy_mask = '0;
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) cycle(1'b1, B_STOP, 4'd0, 1'b0);
         else        cycle(1'b0, B_LOAD, 4'd0, 1'b0);
         done_mask[k] = s_vec[2];
         busy_mask[k] = s_vec[3];
      end
      hold = 1'b0;
      check("stop_wins", done_mask, 32'd0);
      check("stop_idle", {31'd0, busy_mask[6]}, 32'd0);
      check("mode_persist", {30'd0, s_vec[11:10]}, 32'd2);

      // Reset mid-RUN.
      cycle(1'b1, B_START, 4'd9, 1'b0);
      for (int k = 1; k <= 3; k++) cycle(1'b0, B_LOAD, 4'd0, 1'b0);
      cycle(1'b0, B_LOAD, 4'd0, 1'b1);
      cmd_valid = 1'b0; rst = 1'b0;
      #1;
      check("rst_run", {20'd0, dut_vec}, 32'h001);

      // Reset mid-LOAD.
      cycle(1'b1, B_SETMODE, 4'd1, 1'b0);
      cycle(1'b1, B_LOAD, 4'd4, 1'b0);
      cycle(1'b0, B_LOAD, 4'd0, 1'b1);
      cmd_valid = 1'b0; rst = 1'b0;
      #1;
      check("rst_load", {20'd0, dut_vec}, 32'h001);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic       rv, rr;
         logic [1:0] rop;
         logic [3:0] rarg;
         rv   = 1'($urandom_range(0, 1));
         rop  = 2'($urandom_range(0, 3));
         rarg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         rr   = ($urandom_range(0, 199) == 0);
         cycle(rv, rop, rarg, rr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
